// File: rtl/neopixel_tx.sv
// neopixel_tx: multi-channel WS2812 / SK6812 one-wire NRZ transmitter.
// All CHANNELS strings are shifted in lockstep from one valid/ready pixel
// stream. The block generates bit timing, the inter-frame latch interval and
// sticky underrun detection when a frame stalls long enough to latch.
// Build option: define NEOPIXEL_RGBW_EN for 32-bit RGBW pixels (SK6812);
// otherwise pixels are 24-bit GRB (WS2812).
module neopixel_tx #(
    parameter int CHANNELS = 8,
    parameter int T0H_CYC  = 4,
    parameter int T1H_CYC  = 8,
    parameter int TBIT_CYC = 15,
    parameter int TRES_CYC = 3600,
`ifdef NEOPIXEL_RGBW_EN
    localparam int BPP     = 32
`else
    localparam int BPP     = 24
`endif
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [CHANNELS*BPP-1:0] s_data,
    input  logic                    s_last,
    output logic [CHANNELS-1:0]     dout,
    output logic                    busy,
    output logic                    underrun
);

    localparam int CYW = $clog2(TBIT_CYC);
    localparam int BW  = $clog2(BPP);
    localparam int GW  = $clog2(TRES_CYC + 1);

    localparam logic [CYW-1:0] CYC_LAST     = CYW'(TBIT_CYC - 1);
    localparam logic [CYW-1:0] T0H          = CYW'(T0H_CYC);
    localparam logic [CYW-1:0] T1H          = CYW'(T1H_CYC);
    localparam logic [BW-1:0]  BIT_FIRST    = BW'(BPP - 1);
    localparam logic [GW-1:0]  GAP_UNDERRUN = GW'(TRES_CYC - 1);
    localparam logic [GW-1:0]  GAP_LATCH    = GW'(TRES_CYC);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_LATCH
    } state_e;

    state_e                state_q, state_d;
    logic [CYW-1:0]        cyc_q;
    logic [BW-1:0]         bit_q;
    logic [GW-1:0]         gap_q;
    logic                  last_q;
    logic                  underrun_q;
    logic                  rdy_en_q;
    logic [CHANNELS-1:0]   dout_q, dout_d;
    logic [BPP-1:0]        shreg_q [CHANNELS];

    logic                  ready_raw;
    logic                  accept;
    logic                  bit_end;
    logic                  pix_end;

    assign bit_end  = (state_q == ST_SEND) && (cyc_q == CYC_LAST);
    assign pix_end  = bit_end && (bit_q == '0);
    // rdy_en_q holds s_ready low during reset and releases it on the first edge.
    assign s_ready  = rdy_en_q & ready_raw;
    assign accept   = s_valid & s_ready;
    assign busy     = (state_q != ST_IDLE);
    assign dout     = dout_q;
    assign underrun = underrun_q;

    // State register.
    // NOTE: sequential state is always written with <= so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // NOTE: state_d takes a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (pix_end) begin
                    if (last_q)      state_d = ST_LATCH;
                    else if (accept) state_d = ST_SEND;
                    else             state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (accept)                      state_d = ST_SEND;
                else if (gap_q == GAP_UNDERRUN)  state_d = ST_IDLE;
            end
            ST_LATCH: begin
                if (gap_q == GAP_LATCH) state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: ready window and the per-channel high phase of the current bit.
    always_comb begin
        ready_raw = 1'b0;
        dout_d    = '0;
        unique case (state_q)
            ST_IDLE:  ready_raw = 1'b1;
            ST_SEND: begin
                // Final cycle of a non-last pixel: accept the next beat with no gap.
                ready_raw = pix_end && !last_q;
                for (int c = 0; c < CHANNELS; c++) begin
                    dout_d[c] = (cyc_q < (shreg_q[c][BPP-1] ? T1H : T0H));
                end
            end
            ST_WAIT:  ready_raw = 1'b1;
            ST_LATCH: ready_raw = 1'b0;
        endcase
    end

    // Counters, flags and the registered serial outputs.
    // The LATCH counter runs to TRES_CYC inclusive because dout lags the
    // state by one cycle; the low interval seen on the pins is TRES_CYC.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cyc_q      <= '0;
            bit_q      <= '0;
            gap_q      <= '0;
            last_q     <= 1'b0;
            underrun_q <= 1'b0;
            rdy_en_q   <= 1'b0;
            dout_q     <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            dout_q   <= dout_d;
            if (accept) begin
                cyc_q  <= '0;
                bit_q  <= BIT_FIRST;
                gap_q  <= '0;
                last_q <= s_last;
            end else if (state_q == ST_SEND) begin
                gap_q <= '0;
                if (bit_end) begin
                    cyc_q <= '0;
                    bit_q <= bit_q - 1'b1;
                end else begin
                    cyc_q <= cyc_q + 1'b1;
                end
            end else if (state_q == ST_WAIT || state_q == ST_LATCH) begin
                gap_q <= gap_q + 1'b1;
            end
            if (state_q == ST_WAIT && !accept && gap_q == GAP_UNDERRUN) begin
                underrun_q <= 1'b1;
            end
        end
    end

    // Per-channel pixel shift registers: load on accept, shift at bit wrap.
    // NOTE: these data registers carry no reset; they are always loaded on
    // accept before any bit of them reaches dout.
    always_ff @(posedge CLK) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (accept) begin
                shreg_q[c] <= s_data[c*BPP +: BPP];
            end else if (bit_end) begin
                shreg_q[c] <= {shreg_q[c][BPP-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_neopixel_tx.sv
// Directed self-checking bench for neopixel_tx (default timing parameters).
module tb_neopixel_tx;

    localparam int CH   = 8;
    localparam int T0H  = 4;
    localparam int T1H  = 8;
    localparam int TBIT = 15;
    localparam int TRES = 3600;
`ifdef NEOPIXEL_RGBW_EN
    localparam int BPP  = 32;
`else
    localparam int BPP  = 24;
`endif
    localparam int PIX  = BPP * TBIT;

    typedef logic [CH*BPP-1:0] beat_t;

    logic          CLK    = 1'b0;
    logic          RST_N  = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    beat_t         s_data = '0;
    logic          s_last = 1'b0;
    logic [CH-1:0] dout;
    logic          busy;
    logic          underrun;

    int checks = 0;
    int errors = 0;

    neopixel_tx #(
        .CHANNELS (CH),
        .T0H_CYC  (T0H),
        .T1H_CYC  (T1H),
        .TBIT_CYC (TBIT),
        .TRES_CYC (TRES)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .dout     (dout),
        .busy     (busy),
        .underrun (underrun)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t fill(input logic [BPP-1:0] v);
        beat_t r;
        for (int c = 0; c < CH; c++) r[c*BPP +: BPP] = v;
        return r;
    endfunction

    function automatic beat_t one(input int ch, input logic [BPP-1:0] v);
        beat_t r;
        r = '0;
        r[ch*BPP +: BPP] = v;
        return r;
    endfunction

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic accept_beat(input beat_t d, input logic last, input string tag);
        int n;
        n = 0;
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_ready_to_accept"}, 64'(s_ready), 64'(1));
        @(posedge CLK);
        @(negedge CLK);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = ~d;
    endtask

    // Samples one full pixel on every channel against the NRZ model.
    // Optionally presents the next beat for a gapless hand-off.
    task automatic check_pixel(input beat_t d, input logic cur_last, input logic nxt_valid,
                               input beat_t nd, input logic nl, input string tag);
        int bad [CH];
        int bad_busy;
        int rdy;
        int b;
        int cyc;
        logic bv;
        logic e;
        bad_busy = 0;
        rdy      = 0;
        for (int c = 0; c < CH; c++) bad[c] = 0;
        if (nxt_valid) begin
            s_valid = 1'b1;
            s_data  = nd;
            s_last  = nl;
        end
        for (int i = 0; i < PIX; i++) begin
            @(negedge CLK);
            b   = i / TBIT;
            cyc = i % TBIT;
            for (int c = 0; c < CH; c++) begin
                bv = d[c*BPP + BPP - 1 - b];
                e  = (cyc < (bv ? T1H : T0H));
                if (dout[c] !== e) bad[c]++;
            end
            if (busy !== 1'b1) bad_busy++;
            if (i < PIX - 1 && s_ready === 1'b1) rdy++;
        end
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("%s_ch%0d_wave_errs", tag, c), 64'(bad[c]), 64'(0));
        end
        chk({tag, "_busy_errs"}, 64'(bad_busy), 64'(0));
        chk({tag, "_ready_cycles"}, 64'(rdy), cur_last ? 64'(0) : 64'(1));
        if (nxt_valid) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
            s_data  = ~nd;
        end
    endtask

    // Called at the negedge holding the last sample of a last pixel.
    task automatic check_latch(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < TRES; i++) begin
            @(negedge CLK);
            if (dout !== '0 || busy !== 1'b1 || s_ready !== 1'b0) bad++;
        end
        chk({tag, "_latch_errs"}, 64'(bad), 64'(0));
        @(negedge CLK);
        chk({tag, "_latch_ready"}, 64'(s_ready), 64'(1));
        chk({tag, "_latch_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        beat_t a, b, d;
        logic [BPP-1:0] m;
        int bad;

        a = fill(BPP'(24'hAAAAAA));
        b = fill(BPP'(24'h555555));

        // Reset state while RST_N is held low.
        #12;
        chk("rst_ready", 64'(s_ready), 64'(0));
        chk("rst_dout", 64'(dout), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_underrun", 64'(underrun), 64'(0));
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("rel_ready_before_edge", 64'(s_ready), 64'(0));
        @(negedge CLK);
        chk("rel_ready_after_edge", 64'(s_ready), 64'(1));

        // Single pixel, channel 0 = 0xFF0000, then latch.
        d = one(0, BPP'(24'hFF0000));
        accept_beat(d, 1'b1, "t1");
        chk("t1_dout_before_first_bit", 64'(dout), 64'(0));
        check_pixel(d, 1'b1, 1'b0, '0, 1'b0, "t1");
        check_latch("t1");

        // Back-to-back beats: 48 contiguous bit periods.
        accept_beat(a, 1'b0, "t2a");
        check_pixel(a, 1'b0, 1'b1, b, 1'b1, "t2a");
        check_pixel(b, 1'b1, 1'b0, '0, 1'b0, "t2b");
        check_latch("t2");

        // Second beat 100 cycles late: low gap, no underrun.
        accept_beat(a, 1'b0, "t3a");
        check_pixel(a, 1'b0, 1'b0, '0, 1'b0, "t3a");
        bad = 0;
        for (int i = 0; i < 99; i++) begin
            @(negedge CLK);
            if (dout !== '0 || s_ready !== 1'b1 || busy !== 1'b1) bad++;
        end
        chk("t3_gap_errs", 64'(bad), 64'(0));
        accept_beat(b, 1'b1, "t3b");
        chk("t3_gap_last_low", 64'(dout), 64'(0));
        chk("t3_no_underrun", 64'(underrun), 64'(0));
        check_pixel(b, 1'b1, 1'b0, '0, 1'b0, "t3b");
        check_latch("t3");
        chk("t3_underrun_after", 64'(underrun), 64'(0));

        // Stall of TRES cycles: underrun, back to idle.
        accept_beat(a, 1'b0, "t4");
        check_pixel(a, 1'b0, 1'b0, '0, 1'b0, "t4");
        bad = 0;
        for (int i = 0; i < TRES - 1; i++) begin
            @(negedge CLK);
            if (underrun !== 1'b0 || busy !== 1'b1 || dout !== '0) bad++;
        end
        chk("t4_wait_errs", 64'(bad), 64'(0));
        @(negedge CLK);
        chk("t4_underrun", 64'(underrun), 64'(1));
        chk("t4_busy", 64'(busy), 64'(0));
        chk("t4_ready", 64'(s_ready), 64'(1));

        // Reset mid-pixel at bit 10 (high phase of every channel).
        accept_beat(b, 1'b1, "t5");
        repeat (10 * TBIT + 3) @(negedge CLK);
        chk("t5_underrun_sticky", 64'(underrun), 64'(1));
        chk("t5_dout_high_bit10", 64'(dout), 64'({CH{1'b1}}));
        #2;
        RST_N = 1'b0;
        #1;
        chk("t5_rst_dout", 64'(dout), 64'(0));
        chk("t5_rst_ready", 64'(s_ready), 64'(0));
        chk("t5_rst_underrun", 64'(underrun), 64'(0));
        chk("t5_rst_busy", 64'(busy), 64'(0));
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        // Fresh frame: each channel carries 1 << c.
        d = '0;
        for (int c = 0; c < CH; c++) d[c*BPP +: BPP] = BPP'(1) << c;
        accept_beat(d, 1'b1, "t6");
        check_pixel(d, 1'b1, 1'b0, '0, 1'b0, "t6");
        check_latch("t6");

        // First and last bit set: frame is exactly BPP bit periods.
        m = '0;
        m[BPP-1] = 1'b1;
        m[0] = 1'b1;
        d = one(0, m);
        accept_beat(d, 1'b1, "t7");
        check_pixel(d, 1'b1, 1'b0, '0, 1'b0, "t7");
        check_latch("t7");
        chk("t7_underrun", 64'(underrun), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
